// File: rtl/uart_rx.sv
// uart_rx: receive side of the XBee UART link (8N1, LSB first).
// The rx line is synchronized and sampled on an oversample tick. The start
// bit is checked at its middle, and each data and stop bit is sampled at its
// middle. Each good byte is presented with a one-cycle valid pulse. A low
// stop bit gives a one-cycle frame_err pulse and the byte is dropped.
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   rst_n      asynchronous, active-low reset
//   enable     receiver enable; low aborts any frame and holds IDLE
//   rx         serial input from XBee DOUT; asynchronous, idle high
//   data[7:0]  last good byte; held until the next good frame
//   valid      one-cycle pulse: data was updated this cycle
//   frame_err  one-cycle pulse: stop bit sampled low, byte dropped
//   busy       high in any state other than IDLE
module uart_rx #(
  parameter int unsigned CLKFREQ    = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TICK_DEN = BAUD * OVERSAMPLE;
  localparam int unsigned TICK_TOP = (CLKFREQ + TICK_DEN - 1) / TICK_DEN;
  localparam int unsigned DIV_W    = (TICK_TOP > 1) ? $clog2(TICK_TOP) : 1;
  localparam int unsigned SAMP_W   = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_TOP - 1);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_s;
  logic              tick;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      div_q       <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      div_q       <= div_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    rx_prev_d   = sync2_q;
    state_d     = state_q;
    div_d       = div_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    tick = (state_q != S_IDLE) && (div_q == DIV_LAST);

    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
    if (tick) begin
      samp_d = samp_q + SAMP_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        // Divider held at zero so the bit phase is aligned to the start edge.
        div_d  = '0;
        samp_d = '0;
        bit_d  = '0;
        if (enable && rx_prev_q && !rx_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick && samp_q == SAMP_MID) begin
          samp_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && samp_q == SAMP_LAST) begin
          samp_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick && samp_q == SAMP_LAST) begin
          samp_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Only a high line re-arms; a held-low line must not look like a start.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d     = S_IDLE;
      div_d       = '0;
      samp_d      = '0;
      bit_d       = '0;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (160 clk per bit).
// It drives serial frames on rx and checks valid/frame_err pulse counts,
// received data, latency, busy behaviour, enable abort and async reset.
// The ports of uart_rx are listed in the header of rtl/uart_rx.sv.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLKFREQ   (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts output pulses and flags pulse-rule violations.
  int unsigned valid_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned pulse_viol = 0;
  int unsigned last_valid_cyc = 0;
  logic        prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if ((valid && frame_err) || ((valid || frame_err) && prev_pulse))
      pulse_viol <= pulse_viol + 1;
    prev_pulse <= valid || frame_err;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int unsigned act,
                             input int unsigned lo, input int unsigned hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, stop bit; rx is left at the stop value.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop_bit;
    wait_clks(BIT_CLKS);
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        stop;
    int unsigned gap;
    logic [7:0]  exp_data;
    int unsigned exp_valid;
    int unsigned exp_ferr;
  } vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[6];
    int unsigned v0, f0, t0, busy_cnt;
    logic [7:0]  model_last;
    logic [7:0]  rb;
    logic        rstop;
    int unsigned rgap;

    // Zero gap on the first entries makes them back-to-back frames.
    vecs[0] = '{8'h00, 1'b1, 0,  8'h00, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 0,  8'hFF, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 0,  8'h3C, 1, 0};
    vecs[3] = '{8'h96, 1'b0, 30, 8'h3C, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 10, 8'h81, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 0,  8'h01, 1, 0};

    rst_n  = 1'b0;
    enable = 1'b1;
    rx     = 1'b1;
    wait_clks(5);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 0);
    check("reset_ferr", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    wait_clks(20);

    // Single frame and its latency from the start edge.
    v0 = valid_cnt; f0 = ferr_cnt; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    wait_clks(20);
    check("a5_valid_cnt", valid_cnt - v0, 1);
    check("a5_ferr_cnt", ferr_cnt - f0, 0);
    check("a5_data", 32'(data), 32'hA5);
    check_range("a5_latency", last_valid_cyc - t0, 1521, 1526);

    foreach (vecs[i]) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].b, vecs[i].stop);
      rx = 1'b1;
      wait_clks(vecs[i].gap);
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
    end
    wait_clks(50);

    // 40-clk low glitch on an idle line.
    v0 = valid_cnt; f0 = ferr_cnt; busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 340; i++) begin
      if (i == 40) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check_range("glitch_busy_clks", busy_cnt, 1, 99);

    // Low stop bit, line held low, then recovery.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    wait_clks(2000);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", valid_cnt - v0, 0);
    check("break_data_held", 32'(data), 32'h01);
    check("break_busy", 32'(busy), 1);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    send_frame(8'h81, 1'b1);
    wait_clks(20);
    check("after_break_valid", valid_cnt - v0, 1);
    check("after_break_ferr", ferr_cnt - f0, 1);
    check("after_break_data", 32'(data), 32'h81);

    // enable dropped in the middle of bit 4.
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      wait_clks(BIT_CLKS);
    end
    rx = 1'b0;
    wait_clks(80);
    check("en_busy_before", 32'(busy), 1);
    enable = 1'b0;
    wait_clks(1);
    check("en_busy_after", 32'(busy), 0);
    wait_clks(79);
    for (int i = 5; i < 8; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      wait_clks(BIT_CLKS);
    end
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("en_no_valid", valid_cnt - v0, 0);
    check("en_no_ferr", ferr_cnt - f0, 0);
    check("en_data_held", 32'(data), 32'h81);
    enable = 1'b1;
    wait_clks(20);
    send_frame(8'h12, 1'b1);
    wait_clks(20);
    check("en_resume_data", 32'(data), 32'h12);
    check("en_resume_valid", valid_cnt - v0, 1);

    // Asynchronous reset pulse during bit 2 of a frame.
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b0; wait_clks(BIT_CLKS);
    rx = 1'b1; wait_clks(BIT_CLKS);
    rx = 1'b1; wait_clks(60);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", 32'(data), 32'h00);
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_ferr", 32'(frame_err), 0);
    rx = 1'b1;
    wait_clks(1);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h7E, 1'b1);
    wait_clks(20);
    check("post_rst_data", 32'(data), 32'h7E);
    check("post_rst_valid", valid_cnt - v0, 1);

    // Random frames against a byte-level model.
    model_last = 8'h7E;
    for (int i = 0; i < 24; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rgap  = rstop ? $urandom_range(0, 150) : $urandom_range(10, 150);
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(rb, rstop);
      rx = 1'b1;
      wait_clks(rgap);
      if (rstop) model_last = rb;
      check($sformatf("rand%0d_valid", i), valid_cnt - v0, rstop ? 1 : 0);
      check($sformatf("rand%0d_ferr", i), ferr_cnt - f0, rstop ? 0 : 1);
      check($sformatf("rand%0d_data", i), 32'(data), 32'(model_last));
    end

    wait_clks(5);
    check("pulse_rules", pulse_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
